// File: rtl/bram_dp_be_if.sv
// Port bundle for the dual-port byte-enable block RAM.
// Handshake: there is no ready signal. An access on port x is taken on a
// rising clock edge when enable_x=1 and busy=0; it cannot be stalled. Each
// taken read produces exactly one rvalid_x pulse, 1+OUT_REG cycles later,
// with q_x valid in that same cycle. Writes never produce rvalid_x.
interface bram_dp_be_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
);
  localparam int NB = WIDTH / 8;

  logic              enable_a;
  logic              wren_a;
  logic [NB-1:0]     byteena_a;
  logic [ADDR_W-1:0] address_a;
  logic [WIDTH-1:0]  data_a;
  logic [WIDTH-1:0]  q_a;
  logic              rvalid_a;

  logic              enable_b;
  logic              wren_b;
  logic [NB-1:0]     byteena_b;
  logic [ADDR_W-1:0] address_b;
  logic [WIDTH-1:0]  data_b;
  logic [WIDTH-1:0]  q_b;
  logic              rvalid_b;

  logic              clear_req;
  logic              busy;
  logic              collision;
  // Debug view of the controller state: 0 = RUN, 1 = CLEAR.
  logic              dbg_state;

  modport master (
    output enable_a, wren_a, byteena_a, address_a, data_a,
    output enable_b, wren_b, byteena_b, address_b, data_b,
    output clear_req,
    input  q_a, rvalid_a, q_b, rvalid_b, busy, collision, dbg_state
  );

  modport slave (
    input  enable_a, wren_a, byteena_a, address_a, data_a,
    input  enable_b, wren_b, byteena_b, address_b, data_b,
    input  clear_req,
    output q_a, rvalid_a, q_b, rvalid_b, busy, collision, dbg_state
  );
endinterface

// File: rtl/bram_dp_be.sv
// True dual-port block RAM with per-byte write enables, optional output
// register, selectable same-port read-during-write behaviour and a
// sequential clear sweep (one word per cycle) after reset or on request.
module bram_dp_be #(
  parameter int               WIDTH          = 16,
  parameter int               ADDR_W         = 10,
  parameter int               OUT_REG        = 0,
  parameter int               RDW_NEW        = 0,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic         clock,
  input logic         reset_n,
  bram_dp_be_if.slave bus
);
  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Per-port views, index 0 = port A, 1 = port B.
  logic              p_en   [2];
  logic              p_we   [2];
  logic [NB-1:0]     p_be   [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [WIDTH-1:0]  p_data [2];
  logic [WIDTH-1:0]  p_old  [2];
  logic [WIDTH-1:0]  p_merged [2];
  logic [WIDTH-1:0]  p_rword  [2];
  logic              acc    [2];
  logic              wr     [2];

  logic [WIDTH-1:0]  s1_q  [2];
  logic              s1_rv [2];
  logic [WIDTH-1:0]  q_out [2];
  logic              rv_out[2];

  logic              collision_r;
  logic              run;

  assign p_en[0]   = bus.enable_a;
  assign p_we[0]   = bus.wren_a;
  assign p_be[0]   = bus.byteena_a;
  assign p_addr[0] = bus.address_a;
  assign p_data[0] = bus.data_a;
  assign p_en[1]   = bus.enable_b;
  assign p_we[1]   = bus.wren_b;
  assign p_be[1]   = bus.byteena_b;
  assign p_addr[1] = bus.address_b;
  assign p_data[1] = bus.data_b;

  assign run = (state == ST_RUN);

  // State register and sweep counter; reset aborts any sweep in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: clear_req only matters in RUN; the sweep ends after the last word.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RUN: begin
        if (bus.clear_req) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt == {ADDR_W{1'b1}}) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  // Accepted accesses, the word currently stored, and the byte-merged write word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]      = run & p_en[p];
      wr[p]       = run & p_en[p] & p_we[p];
      p_old[p]    = mem[p_addr[p]];
      p_merged[p] = p_old[p];
      for (int i = 0; i < NB; i++) begin
        if (p_be[p][i]) p_merged[p][i*8 +: 8] = p_data[p][i*8 +: 8];
      end
      p_rword[p] = (wr[p] && (RDW_NEW != 0)) ? p_merged[p] : p_old[p];
    end
  end

  // Memory array (never reset). Port A is applied after port B so it wins on shared lanes.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem[cnt] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr[1] && p_be[1][i]) mem[p_addr[1]][i*8 +: 8] <= p_data[1][i*8 +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr[0] && p_be[0][i]) mem[p_addr[0]][i*8 +: 8] <= p_data[0][i*8 +: 8];
      end
    end
  end

  // First read stage: q updates on any accepted access, rvalid only for reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        s1_q[p]  <= '0;
        s1_rv[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        s1_rv[p] <= acc[p] & ~p_we[p];
        if (acc[p]) s1_q[p] <= p_rword[p];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] s2_q  [2];
      logic             s2_rv [2];
      logic             s1_upd[2];

      // Output pipeline stage: forwards stage-1 data only when stage 1 was loaded.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int p = 0; p < 2; p++) begin
            s1_upd[p] <= 1'b0;
            s2_q[p]   <= '0;
            s2_rv[p]  <= 1'b0;
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            s1_upd[p] <= acc[p];
            s2_rv[p]  <= s1_rv[p];
            if (s1_upd[p]) s2_q[p] <= s1_q[p];
          end
        end
      end

      assign q_out  = s2_q;
      assign rv_out = s2_rv;
    end else begin : g_no_reg
      assign q_out  = s1_q;
      assign rv_out = s1_rv;
    end
  endgenerate

  // Collision pulse: same-address dual write with at least one shared lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= wr[0] & wr[1] & (p_addr[0] == p_addr[1]) & (|(p_be[0] & p_be[1]));
    end
  end

  assign bus.q_a       = q_out[0];
  assign bus.rvalid_a  = rv_out[0];
  assign bus.q_b       = q_out[1];
  assign bus.rvalid_b  = rv_out[1];
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.collision = collision_r;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_bram_dp_be.sv
// Directed bench for bram_dp_be: WIDTH=16, ADDR_W=4, CLEAR_VALUE=16'hA5A5.
module tb_bram_dp_be;
  localparam int          WIDTH   = 16;
  localparam int          ADDR_W  = 4;
  localparam int          OUT_REG = 0;
  localparam int          RDW_NEW = 0;
  localparam int          LAT     = 1 + OUT_REG;
  localparam logic [15:0] CV      = 16'hA5A5;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bram_dp_be_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  bram_dp_be #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .OUT_REG(OUT_REG), .RDW_NEW(RDW_NEW),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.enable_a  = 1'b0; bus.wren_a = 1'b0; bus.byteena_a = '0;
    bus.address_a = '0;   bus.data_a = '0;
    bus.enable_b  = 1'b0; bus.wren_b = 1'b0; bus.byteena_b = '0;
    bus.address_b = '0;   bus.data_b = '0;
    bus.clear_req = 1'b0;
  endtask

  task automatic write_a(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    idle();
    bus.enable_a = 1'b1; bus.wren_a = 1'b1; bus.address_a = addr;
    bus.data_a = data;   bus.byteena_a = be;
    tick();
    idle();
  endtask

  task automatic dual_write(input logic [3:0] addr, input logic [15:0] da, input logic [15:0] db,
                            input logic [1:0] bea, input logic [1:0] beb);
    idle();
    bus.enable_a = 1'b1; bus.wren_a = 1'b1; bus.address_a = addr; bus.data_a = da; bus.byteena_a = bea;
    bus.enable_b = 1'b1; bus.wren_b = 1'b1; bus.address_b = addr; bus.data_b = db; bus.byteena_b = beb;
    tick();
    idle();
  endtask

  // Issues one read, waits (bounded) for rvalid, checks latency and data.
  task automatic read_port(input bit port_b, input logic [3:0] addr, input logic [15:0] exp,
                           input string tag);
    int n;
    logic rv;
    logic [15:0] e;
    exp_q.push_back(exp);
    idle();
    if (port_b) begin
      bus.enable_b = 1'b1; bus.address_b = addr;
    end else begin
      bus.enable_a = 1'b1; bus.address_a = addr;
    end
    tick();
    idle();
    n  = 1;
    rv = port_b ? bus.rvalid_b : bus.rvalid_a;
    while (!rv && n < LAT + 4) begin
      tick();
      n++;
      rv = port_b ? bus.rvalid_b : bus.rvalid_a;
    end
    e = exp_q.pop_front();
    if (rv) begin
      check({tag, "_lat"}, n, LAT);
      check(tag, port_b ? bus.q_b : bus.q_a, e);
    end else begin
      check({tag, "_timeout"}, 0, 1);
    end
  endtask

  // Counts busy cycles while hammering both ports; optional mid-sweep clear_req.
  task automatic sweep(input bit pulse_mid, output int n, output bit saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (bus.busy && n < 40) begin
      bus.enable_a = 1'b1; bus.wren_a = 1'b1; bus.address_a = 4'd0;
      bus.data_a = 16'hDEAD; bus.byteena_a = 2'b11;
      bus.enable_b = 1'b1; bus.wren_b = 1'b0; bus.address_b = 4'd3;
      bus.clear_req = pulse_mid && (n == 5);
      tick();
      n++;
      if (bus.rvalid_a || bus.rvalid_b) saw_rv = 1'b1;
    end
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    bit  saw;
    logic [15:0] rdw_exp;

    idle();
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_q_a", bus.q_a, 0);
    check("rst_q_b", bus.q_b, 0);
    check("rst_rvalid", {bus.rvalid_a, bus.rvalid_b}, 0);
    check("rst_collision", bus.collision, 0);

    // Release reset: sweep lasts 16 cycles, accesses meanwhile ignored.
    reset_n = 1'b1;
    sweep(1'b0, n, saw);
    check("init_busy_cycles", n, 16);
    check("init_no_rvalid", saw, 0);
    check("init_state_run", bus.dbg_state, 0);
    for (int a = 0; a < 16; a++) read_port(1'b1, a[3:0], CV, $sformatf("clr_b%0d", a));
    read_port(1'b0, 4'd9, CV, "clr_a9");

    // Byte-lane writes.
    write_a(4'd3, 16'h1234, 2'b11);
    write_a(4'd3, 16'hFFCD, 2'b01);
    read_port(1'b1, 4'd3, 16'h12CD, "be_merge");
    write_a(4'd3, 16'hFFFF, 2'b00);
    read_port(1'b0, 4'd3, 16'h12CD, "be_none");

    // Dual writes to the same address.
    dual_write(4'd5, 16'h1111, 16'h2222, 2'b11, 2'b11);
    check("coll_pulse", bus.collision, 1);
    tick();
    check("coll_one_cycle", bus.collision, 0);
    read_port(1'b1, 4'd5, 16'h1111, "coll_a_wins");
    dual_write(4'd5, 16'h1111, 16'h2222, 2'b01, 2'b10);
    check("disjoint_no_coll", bus.collision, 0);
    read_port(1'b0, 4'd5, 16'h2211, "disjoint_merge");

    // Read-during-write, same port and cross port.
    write_a(4'd7, 16'h0001, 2'b11);
    rdw_exp = (RDW_NEW != 0) ? 16'h00FF : 16'h0001;
    exp_q.push_back(16'h0001);
    bus.enable_a = 1'b1; bus.wren_a = 1'b1; bus.address_a = 4'd7;
    bus.data_a = 16'h00FF; bus.byteena_a = 2'b11;
    bus.enable_b = 1'b1; bus.address_b = 4'd7;
    tick();
    idle();
    n = 1;
    while (!bus.rvalid_b && n < LAT + 4) begin
      tick();
      n++;
    end
    check("rdw_q_a", bus.q_a, rdw_exp);
    check("rdw_no_rvalid_a", bus.rvalid_a, 0);
    check("cross_rvalid_b", bus.rvalid_b, 1);
    check("cross_old_b", bus.q_b, exp_q.pop_front());
    read_port(1'b1, 4'd7, 16'h00FF, "rdw_after");
    tick();
    tick();
    check("q_b_hold", bus.q_b, 16'h00FF);
    check("rvalid_b_pulse", bus.rvalid_b, 0);

    // Clear request, reset at counter 8, sweep restarts from 0.
    write_a(4'd12, 16'h0C0C, 2'b11);
    bus.clear_req = 1'b1;
    tick();
    idle();
    check("clr_req_busy", bus.busy, 1);
    for (int k = 0; k < 8; k++) tick();
    reset_n = 1'b0;
    #1;
    check("midsweep_rst_busy", bus.busy, 1);
    check("midsweep_rst_q_b", bus.q_b, 0);
    tick();
    reset_n = 1'b1;
    sweep(1'b1, n, saw);
    check("restart_busy_cycles", n, 16);
    check("restart_no_rvalid", saw, 0);
    read_port(1'b1, 4'd12, CV, "restart_clr12");
    read_port(1'b0, 4'd3, CV, "restart_clr3");
    read_port(1'b1, 4'd0, CV, "restart_clr0");

    // Reset while a read result is presented discards it.
    bus.enable_a = 1'b1; bus.address_a = 4'd1;
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    check("rst_kill_rvalid", bus.rvalid_a, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_no_rvalid", bus.rvalid_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_dp_be.md
BRAM_DP_BE -- requirements
Module: bram_dp_be

Interface
REQ-001 SHALL: parameter WIDTH, default 16; data width in bits, a multiple of 8; NB = WIDTH/8 byte lanes.
REQ-002 SHALL: parameter ADDR_W, default 10; address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL: parameter OUT_REG, default 0; 1 adds one output pipeline register per port.
REQ-004 SHALL: parameter RDW_NEW, default 0; same-port read-during-write returns 0 = old data, 1 = new (byte-merged) data.
REQ-005 SHALL: parameter CLEAR_ON_RESET, default 1; 1 starts a clear sweep after reset.
REQ-006 SHALL: parameter CLEAR_VALUE, default 0; WIDTH-bit fill word for clear sweeps.
REQ-007 SHALL: one clock; reset is asynchronous and active-low (clock, reset_n).
REQ-008 SHALL: clock  in  1  sole clock; all state on rising edge.
REQ-009 SHALL: reset_n  in  1  asynchronous active-low reset.
REQ-010 SHALL: enable_a / enable_b  in  1  port access enable.
REQ-011 SHALL: wren_a / wren_b  in  1  write when enabled, else read.
REQ-012 SHALL: byteena_a / byteena_b  in  NB  per-lane write enable.
REQ-013 SHALL: address_a / address_b  in  ADDR_W  word address.
REQ-014 SHALL: data_a / data_b  in  WIDTH  write data.
REQ-015 SHALL: q_a / q_b  out  WIDTH  read data.
REQ-016 SHALL: rvalid_a / rvalid_b  out  1  one-cycle pulse marking valid q for an accepted read.
REQ-017 SHALL: clear_req  in  1  pulse starting a clear sweep.
REQ-018 SHALL: busy  out  1  high while a clear sweep runs.
REQ-019 SHALL: collision  out  1  one-cycle pulse on a conflicting dual write.

Function
REQ-020 SHALL: FSM states RUN and CLEAR; reset exit goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-021 SHALL: CLEAR writes CLEAR_VALUE to one address per cycle, counter 0 to DEPTH-1, all lanes; busy=1; both ports ignored (no writes, no rvalid).
REQ-022 SHALL: CLEAR lasts exactly DEPTH cycles; RUN and busy=0 on the cycle after address DEPTH-1 is written.
REQ-023 SHALL: clear_req in RUN enters CLEAR on the next edge with counter 0; clear_req during CLEAR is ignored.
REQ-024 SHALL: accepted access = RUN and enable_x=1; a write updates only lanes with byteena_x=1.
REQ-025 SHALL: read latency 1+OUT_REG cycles from accepted access to q_x update with rvalid_x=1.
REQ-026 SHALL: q_x holds its last value when no read completes; writes also update q_x per REQ-027.
REQ-027 SHALL: same-port write returns the old word on q_x if RDW_NEW=0, the byte-merged new word if RDW_NEW=1; rvalid_x stays 0 for writes.
REQ-028 SHALL: a port reading an address the other port writes in the same cycle returns the old word.
REQ-029 SHALL: both ports write the same address with overlapping byteena: port A wins on overlapping lanes, non-overlapping lanes both apply, collision=1 next cycle.
REQ-030 SHALL: same-address dual writes with disjoint byteena, or dual reads, do not assert collision.
REQ-031 SHALL: memory contents are not reset; only CLEAR sweeps modify them besides port writes.

Reset
REQ-032 SHALL: while reset_n=0: q_a=q_b=0, rvalid_a=rvalid_b=0, collision=0, counter=0, pipeline registers 0.
REQ-033 SHALL: busy=1 during reset if CLEAR_ON_RESET=1, else 0.
REQ-034 SHALL: reset asserted mid-sweep aborts the sweep; on release the sweep restarts at address 0 (CLEAR_ON_RESET=1) or enters RUN with partial contents (CLEAR_ON_RESET=0).
REQ-035 SHALL: reset asserted mid-read discards in-flight pipeline data; no rvalid after release for pre-reset reads.

Verification (WIDTH=16, ADDR_W=4, CLEAR_VALUE=16'hA5A5)
REQ-036 SHALL: release reset, CLEAR_ON_RESET=1 -> busy high exactly 16 cycles; reads of addresses 0..15 return 16'hA5A5.
REQ-037 SHALL: write A[3]=16'h1234 with byteena 11, then byteena 01 data 16'hFFCD -> read B[3] gives 16'h12CD, rvalid_b after 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles.
REQ-038 SHALL: A and B write addr 5 with byteena 11/11, data 16'h1111/16'h2222 -> mem[5]=16'h1111, collision pulse 1 cycle; byteena 01/10 -> 16'h2211, no collision.
REQ-039 SHALL: mem[7]=16'h0001; port A writes 16'h00FF to 7 -> q_a=16'h0001 (RDW_NEW=0) or 16'h00FF (RDW_NEW=1); port B reading 7 same cycle gets 16'h0001.
REQ-040 SHALL: clear_req in RUN, reset_n low at counter 8 -> on release sweep restarts at 0, busy 16 cycles, accesses during busy ignored.
